// File: rtl/bpc_frame_encoder_if.sv
// ---------------------------------------------------------------------------
// bpc_frame_encoder_if
// Load port of the BPC frame encoder. A new time of day and calendar date is
// offered with a valid/ready handshake. It is taken when ld_valid && ld_ready.
//   master : drives ld_valid and the ld_* fields, samples ld_ready
//   slave  : samples ld_valid and the ld_* fields, drives ld_ready
// Fields: ld_sec 0-59, ld_min 0-59, ld_hr 0-23, ld_wk 1-7 (7 = Sunday),
//         ld_day 1-31, ld_mon 1-12, ld_yr year offset (bit 6 is sent in P4).
// ---------------------------------------------------------------------------
interface bpc_frame_encoder_if;
   logic       ld_valid;
   logic       ld_ready;
   logic [5:0] ld_sec;
   logic [5:0] ld_min;
   logic [4:0] ld_hr;
   logic [2:0] ld_wk;
   logic [4:0] ld_day;
   logic [3:0] ld_mon;
   logic [6:0] ld_yr;

   modport master (
      output ld_valid, ld_sec, ld_min, ld_hr, ld_wk, ld_day, ld_mon, ld_yr,
      input  ld_ready
   );

   modport slave (
      input  ld_valid, ld_sec, ld_min, ld_hr, ld_wk, ld_day, ld_mon, ld_yr,
      output ld_ready
   );
endinterface

// File: rtl/bpc_frame_encoder.sv
// ---------------------------------------------------------------------------
// bpc_frame_encoder
// BPC time-code encoder with a built-in time-of-day register. A prescaler
// derives seconds from i_clk. The time advances once per second and can be
// replaced through the load port. The 20-symbol BPC frame is sent three times
// per minute. Each symbol is a carrier-reduction pulse at the start of its
// second, with a width of (value+1) units. Symbol 0 is a marker and has no
// pulse.
//
// Optional feature: define BPC_CALENDAR_EN to make a day carry advance the
// day, month and year with real month lengths. Without it, only a load
// changes day, month and year.
//
// Ports
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_en           run enable: 0 freezes the time and silences the output
//   ld             load port (bpc_frame_encoder_if.slave)
//   o_bpc/o_bpc_n  carrier-reduce pulse (high = reduced) and its inverse
//   o_sec_tick     strobe on the last cycle of each second
//   o_frame_start  strobe on the first cycle of symbol 0
//   o_sym_idx      current symbol 0-19 (= sec mod 20)
//   o_sym_val      value of the current symbol
// ---------------------------------------------------------------------------
module bpc_frame_encoder #(
   parameter int TICKS_PER_SEC = 100,
   parameter int UNIT_TICKS    = 10
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_en,
   bpc_frame_encoder_if.slave  ld,
   output logic                o_bpc,
   output logic                o_bpc_n,
   output logic                o_sec_tick,
   output logic                o_frame_start,
   output logic [4:0]          o_sym_idx,
   output logic [1:0]          o_sym_val
);

   localparam int            CW      = $clog2(TICKS_PER_SEC);
   localparam logic [CW-1:0] CNT_MAX = CW'(TICKS_PER_SEC - 1);

   function automatic logic [4:0] f_mod20(input logic [5:0] s);
      if (s >= 6'd40)      f_mod20 = 5'(s - 6'd40);
      else if (s >= 6'd20) f_mod20 = 5'(s - 6'd20);
      else                 f_mod20 = s[4:0];
   endfunction

`ifdef BPC_CALENDAR_EN
   function automatic logic [4:0] f_mlen(input logic [3:0] mon, input logic [6:0] yr);
      case (mon)
         4'd2:                      f_mlen = (yr[1:0] == 2'd0) ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:   f_mlen = 5'd30;
         default:                   f_mlen = 5'd31;
      endcase
   endfunction
`endif

   // prescaler and running time
   logic [CW-1:0] r_cnt;
   logic [5:0]    r_sec, r_min;
   logic [4:0]    r_hr, r_day;
   logic [2:0]    r_wk;
   logic [3:0]    r_mon;
   logic [6:0]    r_yr;

   // pending load
   logic          r_pend;
   logic [5:0]    r_p_sec, r_p_min;
   logic [4:0]    r_p_hr, r_p_day;
   logic [2:0]    r_p_wk;
   logic [3:0]    r_p_mon;
   logic [6:0]    r_p_yr;

   // frame snapshot: every symbol of a frame is encoded from this copy
   logic [5:0]    r_s_min;
   logic [4:0]    r_s_hr, r_s_day;
   logic [2:0]    r_s_wk;
   logic [3:0]    r_s_mon;
   logic [6:0]    r_s_yr;

   logic [4:0]    r_sym_idx;
   logic          r_frame_start;
   logic          r_bpc;

   logic          w_tick, w_hs, w_apply, w_snap_en;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_sec_wrap, w_min_wrap, w_day_carry;
   logic [5:0]    w_inc_sec, w_inc_min;
   logic [4:0]    w_inc_hr, w_inc_day;
   logic [2:0]    w_inc_wk;
   logic [3:0]    w_inc_mon;
   logic [6:0]    w_inc_yr;
   logic [5:0]    w_nxt_sec, w_nxt_min;
   logic [4:0]    w_nxt_hr, w_nxt_day;
   logic [2:0]    w_nxt_wk;
   logic [3:0]    w_nxt_mon;
   logic [6:0]    w_nxt_yr;
   logic [4:0]    w_nxt_idx;

   logic [3:0]    w_h12;
   logic          w_pm, w_pt, w_pd;
   logic [1:0]    w_sec20;
   logic [1:0]    w_sym_val;
   logic [CW-1:0] w_pw;

   // ---------------- prescaler / handshake ----------------
   assign w_tick = i_en && (r_cnt == CNT_MAX);
   assign w_hs   = ld.ld_valid && !r_pend;
   // A handshake in the tick cycle is applied by that same tick.
   assign w_apply = w_tick && (r_pend || w_hs);

   always_comb begin
      w_cnt_nxt = '0;
      if (i_en && !w_tick) w_cnt_nxt = r_cnt + 1'b1;
   end

   // ---------------- one-second increment ----------------
   assign w_sec_wrap  = (r_sec == 6'd59);
   assign w_min_wrap  = w_sec_wrap && (r_min == 6'd59);
   assign w_day_carry = w_min_wrap && (r_hr == 5'd23);

   always_comb begin
      w_inc_sec = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
      w_inc_min = r_min;
      w_inc_hr  = r_hr;
      w_inc_wk  = r_wk;
      w_inc_day = r_day;
      w_inc_mon = r_mon;
      w_inc_yr  = r_yr;
      if (w_sec_wrap) w_inc_min = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
      if (w_min_wrap) w_inc_hr  = w_day_carry ? 5'd0 : r_hr + 5'd1;
      if (w_day_carry) w_inc_wk = (r_wk == 3'd7) ? 3'd1 : r_wk + 3'd1;
`ifdef BPC_CALENDAR_EN
      if (w_day_carry) begin
         if (r_day >= f_mlen(r_mon, r_yr)) begin
            w_inc_day = 5'd1;
            if (r_mon >= 4'd12) begin
               w_inc_mon = 4'd1;
               w_inc_yr  = r_yr + 7'd1;   // 127 wraps to 0
            end else begin
               w_inc_mon = r_mon + 4'd1;
            end
         end else begin
            w_inc_day = r_day + 5'd1;
         end
      end
`endif
   end

   // ---------------- time applied by the tick ----------------
   always_comb begin
      w_nxt_sec = w_inc_sec;
      w_nxt_min = w_inc_min;
      w_nxt_hr  = w_inc_hr;
      w_nxt_wk  = w_inc_wk;
      w_nxt_day = w_inc_day;
      w_nxt_mon = w_inc_mon;
      w_nxt_yr  = w_inc_yr;
      if (w_apply && r_pend) begin
         w_nxt_sec = r_p_sec;
         w_nxt_min = r_p_min;
         w_nxt_hr  = r_p_hr;
         w_nxt_wk  = r_p_wk;
         w_nxt_day = r_p_day;
         w_nxt_mon = r_p_mon;
         w_nxt_yr  = r_p_yr;
      end else if (w_apply) begin
         w_nxt_sec = ld.ld_sec;
         w_nxt_min = ld.ld_min;
         w_nxt_hr  = ld.ld_hr;
         w_nxt_wk  = ld.ld_wk;
         w_nxt_day = ld.ld_day;
         w_nxt_mon = ld.ld_mon;
         w_nxt_yr  = ld.ld_yr;
      end
   end

   assign w_nxt_idx = f_mod20(w_nxt_sec);
   assign w_snap_en = w_tick && (w_apply || (w_nxt_idx == 5'd0));

   // ---------------- state registers ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt         <= '0;
         r_sec         <= 6'd0;
         r_min         <= 6'd0;
         r_hr          <= 5'd0;
         r_wk          <= 3'd1;
         r_day         <= 5'd1;
         r_mon         <= 4'd1;
         r_yr          <= 7'd0;
         r_sym_idx     <= 5'd0;
         r_frame_start <= 1'b0;
      end else begin
         r_cnt         <= w_cnt_nxt;
         r_frame_start <= w_tick && (w_nxt_idx == 5'd0);
         if (w_tick) begin
            r_sec     <= w_nxt_sec;
            r_min     <= w_nxt_min;
            r_hr      <= w_nxt_hr;
            r_wk      <= w_nxt_wk;
            r_day     <= w_nxt_day;
            r_mon     <= w_nxt_mon;
            r_yr      <= w_nxt_yr;
            r_sym_idx <= w_nxt_idx;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pend  <= 1'b0;
         r_p_sec <= 6'd0;
         r_p_min <= 6'd0;
         r_p_hr  <= 5'd0;
         r_p_wk  <= 3'd1;
         r_p_day <= 5'd1;
         r_p_mon <= 4'd1;
         r_p_yr  <= 7'd0;
      end else begin
         // Any tick consumes the pending load. A handshake in the tick cycle
         // never becomes pending.
         if (w_tick)    r_pend <= 1'b0;
         else if (w_hs) r_pend <= 1'b1;
         if (w_hs) begin
            r_p_sec <= ld.ld_sec;
            r_p_min <= ld.ld_min;
            r_p_hr  <= ld.ld_hr;
            r_p_wk  <= ld.ld_wk;
            r_p_day <= ld.ld_day;
            r_p_mon <= ld.ld_mon;
            r_p_yr  <= ld.ld_yr;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s_min <= 6'd0;
         r_s_hr  <= 5'd0;
         r_s_wk  <= 3'd1;
         r_s_day <= 5'd1;
         r_s_mon <= 4'd1;
         r_s_yr  <= 7'd0;
      end else if (w_snap_en) begin
         r_s_min <= w_nxt_min;
         r_s_hr  <= w_nxt_hr;
         r_s_wk  <= w_nxt_wk;
         r_s_day <= w_nxt_day;
         r_s_mon <= w_nxt_mon;
         r_s_yr  <= w_nxt_yr;
      end
   end

   // ---------------- symbol encoder ----------------
   assign w_pm  = (r_s_hr >= 5'd12);
   assign w_h12 = w_pm ? 4'(r_s_hr - 5'd12) : r_s_hr[3:0];
   assign w_pt  = (^w_h12) ^ (^r_s_min) ^ (^r_s_wk);
   assign w_pd  = (^r_s_day) ^ (^r_s_mon) ^ (^r_s_yr[5:0]);

   // Symbol 1 carries the third of the minute. It comes from the live
   // second, not from the snapshot.
   always_comb begin
      w_sec20 = 2'd0;
      if (r_sec >= 6'd40)      w_sec20 = 2'd2;
      else if (r_sec >= 6'd20) w_sec20 = 2'd1;
   end

   always_comb begin
      w_sym_val = 2'd0;
      case (r_sym_idx)
         5'd1:  w_sym_val = w_sec20;
         5'd3:  w_sym_val = w_h12[3:2];
         5'd4:  w_sym_val = w_h12[1:0];
         5'd5:  w_sym_val = r_s_min[5:4];
         5'd6:  w_sym_val = r_s_min[3:2];
         5'd7:  w_sym_val = r_s_min[1:0];
         5'd8:  w_sym_val = {1'b0, r_s_wk[2]};
         5'd9:  w_sym_val = r_s_wk[1:0];
         5'd10: w_sym_val = {w_pm, w_pm ^ w_pt};
         5'd11: w_sym_val = {1'b0, r_s_day[4]};
         5'd12: w_sym_val = r_s_day[3:2];
         5'd13: w_sym_val = r_s_day[1:0];
         5'd14: w_sym_val = r_s_mon[3:2];
         5'd15: w_sym_val = r_s_mon[1:0];
         5'd16: w_sym_val = r_s_yr[5:4];
         5'd17: w_sym_val = r_s_yr[3:2];
         5'd18: w_sym_val = r_s_yr[1:0];
         5'd19: w_sym_val = {r_s_yr[6], r_s_yr[6] ^ w_pd};
         default: w_sym_val = 2'd0;
      endcase
   end

   always_comb begin
      w_pw = CW'(UNIT_TICKS);
      case (w_sym_val)
         2'd1:    w_pw = CW'(2 * UNIT_TICKS);
         2'd2:    w_pw = CW'(3 * UNIT_TICKS);
         2'd3:    w_pw = CW'(4 * UNIT_TICKS);
         default: w_pw = CW'(UNIT_TICKS);
      endcase
   end

   // bpc is registered from the next count value. It is therefore high while
   // the registered cnt is in 1..width. The symbol only changes when the next
   // cnt is 0, so the current symbol's width is the right one here.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_bpc <= 1'b0;
      else       r_bpc <= i_en && (r_sym_idx != 5'd0) &&
                          (w_cnt_nxt != '0) && (w_cnt_nxt <= w_pw);
   end

   assign ld.ld_ready     = !r_pend;
   assign o_bpc           = r_bpc;
   assign o_bpc_n         = ~r_bpc;
   assign o_sec_tick      = w_tick;
   assign o_frame_start   = r_frame_start;
   assign o_sym_idx       = r_sym_idx;
   assign o_sym_val       = w_sym_val;

endmodule
